scm_fifo_ctrl: RTL and testbench

- Initiator-side controller that drives a 1-read/1-write latch-based register file as FIFO storage.
- Presents valid/ready push and pop interfaces to the client, and generates the write port (WriteEnable, WriteAddr, WriteData) and read port (ReadEnable, ReadAddr) of the storage.
- Pop data is taken directly from the storage ReadData. The storage registers its read address on ReadEnable, so the controller needs no separate output data register.
- Instantiated alongside the register file in cluster-side buffering paths.

---
 rtl/scm_fifo_if.sv | 32 +++
 rtl/scm_fifo_ctrl.sv | 72 +++++++
 tb/tb_scm_fifo_ctrl.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/scm_fifo_if.sv
// Client and storage-side signal bundle for scm_fifo_ctrl.
// slave is the controller view; master is the client/storage view.
interface scm_fifo_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid_i;
    logic                  in_ready_o;
    logic [DATA_WIDTH-1:0] in_data_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [DATA_WIDTH-1:0] out_data_o;
    logic                  rf_we_o;
    logic [ADDR_WIDTH-1:0] rf_waddr_o;
    logic [DATA_WIDTH-1:0] rf_wdata_o;
    logic                  rf_re_o;
    logic [ADDR_WIDTH-1:0] rf_raddr_o;
    logic [DATA_WIDTH-1:0] rf_rdata_i;
    logic [ADDR_WIDTH:0]   count_o;

    modport slave (
        input  in_valid_i, in_data_i, out_ready_i, rf_rdata_i,
        output in_ready_o, out_valid_o, out_data_o, rf_we_o, rf_waddr_o,
               rf_wdata_o, rf_re_o, rf_raddr_o, count_o
    );

    modport master (
        output in_valid_i, in_data_i, out_ready_i, rf_rdata_i,
        input  in_ready_o, out_valid_o, out_data_o, rf_we_o, rf_waddr_o,
               rf_wdata_o, rf_re_o, rf_raddr_o, count_o
    );
endinterface

// File: rtl/scm_fifo_ctrl.sv
// FIFO controller driving a 1R/1W latch register file with registered read address.
// Optional synchronous flush port enabled by defining SCM_FIFO_FLUSH_EN.
module scm_fifo_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32
) (
    input logic       clk,
    input logic       rst_n,
`ifdef SCM_FIFO_FLUSH_EN
    input logic       flush_i,
`endif
    scm_fifo_if.slave bus
);
    localparam int                DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH:0]   avail;
    logic [ADDR_WIDTH:0]   count_next;
    logic                  out_valid_q;
    logic                  push;
    logic                  pop;
    logic                  fetch;
    logic                  flush;
    logic [DATA_WIDTH-1:0] head_data;

`ifdef SCM_FIFO_FLUSH_EN
    assign flush = flush_i;
`else
    assign flush = 1'b0;
`endif

    assign bus.in_ready_o  = (count != FULL) && !flush;
    assign push            = bus.in_valid_i && bus.in_ready_o;
    assign bus.out_valid_o = out_valid_q;
    assign pop             = out_valid_q && bus.out_ready_i;

    // avail excludes the entry already parked on the storage read port
    assign avail      = count - {{ADDR_WIDTH{1'b0}}, out_valid_q};
    assign fetch      = (avail != '0) && (!out_valid_q || pop) && !flush;
    assign count_next = count + {{ADDR_WIDTH{1'b0}}, push} - {{ADDR_WIDTH{1'b0}}, pop};

    assign bus.rf_we_o    = push;
    assign bus.rf_waddr_o = wr_ptr;
    assign bus.rf_wdata_o = bus.in_data_i;
    assign bus.rf_re_o    = fetch;
    assign bus.rf_raddr_o = rd_ptr;
    assign head_data      = bus.rf_rdata_i;
    assign bus.out_data_o = head_data;
    assign bus.count_o    = count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
        end else if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (fetch) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            count       <= count_next;
            out_valid_q <= fetch || (out_valid_q && !pop);
        end
    end
endmodule

// File: tb/tb_scm_fifo_ctrl.sv
// Directed bench for scm_fifo_ctrl with a behavioural register file and a data scoreboard.
module tb_scm_fifo_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
`ifdef SCM_FIFO_FLUSH_EN
    logic flush_i = 1'b0;
`endif
    int total = 0;
    int bad = 0;
    int pops = 0;
    logic [31:0] sb[$];

    scm_fifo_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

    scm_fifo_ctrl #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef SCM_FIFO_FLUSH_EN
        .flush_i(flush_i),
`endif
        .bus(bus)
    );

    always #5 clk = ~clk;

    // Storage model: write on edge, read address registered on ReadEnable.
    logic [31:0] mem[32];
    logic [4:0]  raddr_q;
    always @(posedge clk) begin
        if (bus.rf_we_o) mem[bus.rf_waddr_o] <= bus.rf_wdata_o;
        if (bus.rf_re_o) raddr_q <= bus.rf_raddr_o;
    end
    assign bus.rf_rdata_i = mem[raddr_q];

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        bus.in_valid_i  = v;
        bus.in_data_i   = d;
        bus.out_ready_i = r;
    endtask

    task automatic step();
        logic [31:0] e;
        @(negedge clk);
        if (bus.out_valid_o && bus.out_ready_i) begin
            pops++;
            if (sb.size() == 0) check("pop_unexpected", 1, 0);
            else begin
                e = sb.pop_front();
                check("pop_data", bus.out_data_o, e);
            end
        end
        if (bus.in_valid_i && bus.in_ready_o) sb.push_back(bus.in_data_i);
        @(posedge clk);
        #1;
`ifdef SCM_FIFO_FLUSH_EN
        if (flush_i) sb.delete();
`endif
        check("count_track", bus.count_o, sb.size());
    endtask

    task automatic drain();
        drive(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 80 && sb.size() != 0; k++) step();
        check("drain_sb_empty", sb.size(), 0);
        drive(1'b0, 32'h0, 1'b0);
        step();
        check("drain_out_valid", bus.out_valid_o, 0);
    endtask

    initial begin
        logic [31:0] head;
        int p0;
        drive(1'b0, 32'h0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid_o, 0);
        check("rst_we", bus.rf_we_o, 0);
        check("rst_re", bus.rf_re_o, 0);
        check("rst_in_ready", bus.in_ready_o, 1);
        check("rst_count", bus.count_o, 0);
        rst_n = 1'b1;

        // single push: write now, fetch next cycle, visible after the second edge
        drive(1'b1, 32'hA5A5_0001, 1'b0);
        #1;
        check("p1_we", bus.rf_we_o, 1);
        check("p1_waddr", bus.rf_waddr_o, 0);
        check("p1_wdata", bus.rf_wdata_o, 32'hA5A5_0001);
        check("p1_no_re", bus.rf_re_o, 0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        #1;
        check("p1_re", bus.rf_re_o, 1);
        check("p1_raddr", bus.rf_raddr_o, 0);
        check("p1_not_valid_yet", bus.out_valid_o, 0);
        step();
        check("p1_valid", bus.out_valid_o, 1);
        check("p1_data", bus.out_data_o, 32'hA5A5_0001);
        check("p1_count", bus.count_o, 1);
        drain();

        // fill to full, refuse the 33rd, then empty in order
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 32'(i), 1'b0);
            step();
        end
        check("full_in_ready", bus.in_ready_o, 0);
        check("full_count", bus.count_o, 32);
        drive(1'b1, 32'h99, 1'b0);
        #1;
        check("full_no_we", bus.rf_we_o, 0);
        step();
        p0 = pops;
        drain();
        check("full_pop_count", pops - p0, 33 - 1);

        // streaming 1 push + 1 pop per cycle
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 32'h1000 + 32'(i), 1'b1);
            #1;
            if (i >= 2) check("stream_no_bubble", bus.out_valid_o, 1);
            step();
            check("stream_count_le2", bus.count_o <= 6'd2, 1);
        end
        drain();

        // full with simultaneous push and pop
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, 32'h200 + 32'(i), 1'b0);
            step();
        end
        drive(1'b1, 32'hDEAD, 1'b1);
        #1;
        check("fpp_in_ready", bus.in_ready_o, 0);
        check("fpp_no_we", bus.rf_we_o, 0);
        step();
        check("fpp_count31", bus.count_o, 31);
        drive(1'b1, 32'hBEEF, 1'b0);
        #1;
        check("fpp_we_next", bus.rf_we_o, 1);
        step();
        check("fpp_count32", bus.count_o, 32);
        drain();

        // head held while other words are pushed
        drive(1'b1, 32'h300, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        step();
        head = bus.out_data_o;
        check("hold_head", head, 32'h300);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h400 + 32'(i), 1'b0);
            #1;
            check("hold_waddr_safe", bus.rf_we_o && (bus.rf_waddr_o == raddr_q), 0);
            step();
            check("hold_data", bus.out_data_o, head);
        end
        drain();

        // asynchronous reset mid-stream
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 32'h500 + 32'(i), 1'b0);
            step();
        end
        check("mid_count7", bus.count_o, 7);
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", bus.out_valid_o, 0);
        check("mid_rst_count", bus.count_o, 0);
        sb.delete();
        drive(1'b0, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h7770 + 32'(i), 1'b0);
            step();
        end
        drain();

`ifdef SCM_FIFO_FLUSH_EN
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h600 + 32'(i), 1'b0);
            step();
        end
        drive(1'b0, 32'h0, 1'b0);
        step();
        drive(1'b1, 32'h6FF, 1'b1);
        flush_i = 1'b1;
        #1;
        check("flush_in_ready", bus.in_ready_o, 0);
        check("flush_we", bus.rf_we_o, 0);
        check("flush_re", bus.rf_re_o, 0);
        step();
        flush_i = 1'b0;
        check("flush_count", bus.count_o, 0);
        check("flush_valid", bus.out_valid_o, 0);
        drive(1'b1, 32'h6AA, 1'b0);
        step();
        drain();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
